// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing front-end for the 4x4 shift-add multiplier.
// Accepts operand pairs on a valid/ready handshake, fires a one-cycle start
// pulse, holds operands until the multiplier reports done, and queues each
// 8-bit product in a small result FIFO drained through a valid/ready port.
// A watchdog flags a multiplier that never reports done (sticky err).
// Optional feature macro: MUL_SIGNED_EN -- when defined, in_signed selects
// two's-complement operation via sign-magnitude conversion around the
// unsigned core; when undefined, in_signed is ignored and all ops are unsigned.
module mul_seq_ctrl #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 63
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_signed,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_prod,
  output logic       busy,
  output logic       err,
  output logic       mul_st,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic       mul_idle,
  input  logic       mul_done,
  input  logic [7:0] mul_prod
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state, next_state;

  logic [3:0]       a_reg, b_reg;
  logic [3:0]       a_conv, b_conv;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             err_reg;
  logic             accept, push, pop, timeout_hit;
  logic [7:0]       push_data;

  assign accept      = in_valid & in_ready;
  assign push        = (state == WAIT) & mul_done;
  assign pop         = out_valid & out_ready;
  assign timeout_hit = (state == WAIT) & ~mul_done &
                       (tmo_cnt == TMO_W'(TIMEOUT - 1));

`ifdef MUL_SIGNED_EN
  logic neg_conv, neg_reg;

  // Convert signed operands to magnitudes and remember the result sign
  always_comb begin
    a_conv   = in_a;
    b_conv   = in_b;
    neg_conv = 1'b0;
    if (in_signed) begin
      a_conv   = in_a[3] ? (~in_a + 4'd1) : in_a;
      b_conv   = in_b[3] ? (~in_b + 4'd1) : in_b;
      neg_conv = in_a[3] ^ in_b[3];
    end
  end

  // Latch the result sign alongside the operands on accept
  always_ff @(posedge Clk) begin
    if (reset) begin
      neg_reg <= 1'b0;
    end else if (accept) begin
      neg_reg <= neg_conv;
    end
  end

  assign push_data = neg_reg ? (~mul_prod + 8'd1) : mul_prod;
`else
  logic unused_in_signed;

  assign unused_in_signed = in_signed;
  assign a_conv           = in_a;
  assign b_conv           = in_b;
  assign push_data        = mul_prod;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; RECOVER waits out a multi-cycle done before re-arming
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (mul_done || timeout_hit) next_state = RECOVER;
      RECOVER: if (mul_idle && !mul_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake, start pulse and status outputs decoded from the state
  always_comb begin
    in_ready = (state == IDLE) & mul_idle &
               (fifo_count < CNT_W'(DEPTH)) & ~err_reg;
    mul_st   = (state == START);
    busy     = (state != IDLE);
  end

  assign mul_a     = a_reg;
  assign mul_b     = b_reg;
  assign err       = err_reg;
  assign out_valid = (fifo_count != '0);
  assign out_prod  = fifo_mem[rd_ptr];

  // Operand holding registers, stable from accept until the next accept
  always_ff @(posedge Clk) begin
    if (reset) begin
      a_reg <= 4'd0;
      b_reg <= 4'd0;
    end else if (accept) begin
      a_reg <= a_conv;
      b_reg <= b_conv;
    end
  end

  // Watchdog counter: cleared on the start cycle, counts WAIT cycles without done
  always_ff @(posedge Clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == START) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT) && !mul_done && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Sticky error flag, only cleared by reset
  always_ff @(posedge Clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  // Result FIFO storage and pointers; accept gating keeps pushes off a full FIFO
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= 8'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // FIFO occupancy; simultaneous push and pop leaves it unchanged
  always_ff @(posedge Clk) begin
    if (reset) begin
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed bench for mul_seq_ctrl with a behavioural
// multiplier stub (configurable latency, done-hold length, hang, abort).
module tb_mul_seq_ctrl;

  localparam int TIMEOUT = 63;

  logic       Clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_signed;
  logic [3:0] in_a, in_b;
  logic       out_valid, out_ready;
  logic [7:0] out_prod;
  logic       busy, err, mul_st;
  logic [3:0] mul_a, mul_b;
  logic       mul_idle, mul_done;
  logic [7:0] mul_prod;

  int checks = 0;
  int errors = 0;

  logic       stub_done;
  logic       stray_done = 1'b0;
  int         stub_latency = 2;
  int         stub_hold = 1;
  bit         stub_hang = 1'b0;
  bit         stub_kick = 1'b0;
  int         stub_phase, stub_cnt;
  logic [7:0] stub_result;

  assign mul_done = stub_done | stray_done;

  mul_seq_ctrl dut (
    .Clk       (Clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy),
    .err       (err),
    .mul_st    (mul_st),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_idle  (mul_idle),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod)
  );

  always #5 Clk = ~Clk;

  // Multiplier stub: starts on mul_st, reports done after a latency, holds it
  always @(posedge Clk) begin
    if (reset) begin
      stub_phase  <= 0;
      stub_cnt    <= 0;
      mul_idle    <= 1'b1;
      stub_done   <= 1'b0;
      mul_prod    <= 8'd0;
      stub_result <= 8'd0;
    end else begin
      case (stub_phase)
        0: if (mul_st) begin
             mul_idle    <= 1'b0;
             stub_result <= 8'(mul_a) * 8'(mul_b);
             stub_cnt    <= stub_latency;
             stub_phase  <= 1;
           end
        1: if (stub_kick) begin
             mul_idle   <= 1'b1;
             stub_phase <= 0;
           end else if (!stub_hang) begin
             if (stub_cnt <= 1) begin
               stub_done  <= 1'b1;
               mul_prod   <= stub_result;
               stub_cnt   <= stub_hold;
               stub_phase <= 2;
             end else begin
               stub_cnt <= stub_cnt - 1;
             end
           end
        default: if (stub_cnt <= 1) begin
                   stub_done  <= 1'b0;
                   mul_idle   <= 1'b1;
                   stub_phase <= 0;
                 end else begin
                   stub_cnt <= stub_cnt - 1;
                 end
      endcase
    end
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    reset = 1'b0;
  endtask

  // Offer an operand pair at a negedge; returns at the negedge after acceptance
  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic s);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge Clk);
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    @(negedge Clk);
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept: in_ready got 0 expected 1 within 40 cycles");
    end
  endtask

  // Bounded wait at negedges: 0=out_valid, 1=not busy, 2=mul_done, 3=err
  task automatic wait_sig(input string name, input int which, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      case (which)
        0:       hit = (out_valid === 1'b1);
        1:       hit = (busy === 1'b0);
        2:       hit = (mul_done === 1'b1);
        default: hit = (err === 1'b1);
      endcase
      if (hit) break;
      @(negedge Clk);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got not-reached expected reached within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, out_valid, busy, err, mul_st} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 10000", {in_ready, out_valid, busy, err, mul_st});
    end
    checks++;
    if ({out_prod, mul_a, mul_b} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0000", {out_prod, mul_a, mul_b});
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    offer(4'd13, 4'd11, 1'b0);
    checks++;
    if ({mul_st, busy, mul_a, mul_b} !== {1'b1, 1'b1, 4'd13, 4'd11}) begin
      errors++;
      $display("[TB] FAIL single_start: got %h expected %h", {mul_st, busy, mul_a, mul_b}, {1'b1, 1'b1, 4'd13, 4'd11});
    end
    @(negedge Clk);
    checks++;
    if (mul_st !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pulse: mul_st got %b expected 0", mul_st);
    end
    wait_sig("single_valid", 0, 20);
    checks++;
    if (out_prod !== 8'h8F) begin
      errors++;
      $display("[TB] FAIL single_prod: got %h expected 8f", out_prod);
    end
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pop: out_valid got %b expected 0", out_valid);
    end
    wait_sig("single_idle", 1, 20);
  endtask

  task automatic test_back_to_back();
    bit blocked = 1'b1;
    out_ready = 1'b0;
    offer(4'd2, 4'd3, 1'b0);
    wait_sig("b2b_idle1", 1, 20);
    offer(4'd15, 4'd15, 1'b0);
    wait_sig("b2b_idle2", 1, 20);
    in_a = 4'd0; in_b = 4'd9; in_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (in_ready !== 1'b0 || busy !== 1'b0) blocked = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (!blocked) begin
      errors++;
      $display("[TB] FAIL b2b_full_block: got accepted expected blocked");
    end
    checks++;
    if ({out_valid, out_prod} !== {1'b1, 8'h06}) begin
      errors++;
      $display("[TB] FAIL b2b_head0: got %h expected 106", {out_valid, out_prod});
    end
    out_ready = 1'b1;
    @(negedge Clk);
    checks++;
    if ({out_valid, out_prod} !== {1'b1, 8'hE1}) begin
      errors++;
      $display("[TB] FAIL b2b_head1: got %h expected 1e1", {out_valid, out_prod});
    end
    @(negedge Clk);
    in_valid = 1'b0;
    checks++;
    if (mul_st !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_third_accept: mul_st got %b expected 1", mul_st);
    end
    wait_sig("b2b_valid3", 0, 20);
    checks++;
    if (out_prod !== 8'h00) begin
      errors++;
      $display("[TB] FAIL b2b_head2: got %h expected 00", out_prod);
    end
    wait_sig("b2b_idle3", 1, 20);
  endtask

  task automatic test_signed();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] ve [3];
    va = '{4'hD, 4'h8, 4'h8};
    vb = '{4'h5, 4'h8, 4'h7};
`ifdef MUL_SIGNED_EN
    ve = '{8'hF1, 8'h40, 8'hC8};
`else
    ve = '{8'h41, 8'h40, 8'h38};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(va[i], vb[i], 1'b1);
      wait_sig("signed_valid", 0, 20);
      checks++;
      if (out_prod !== ve[i]) begin
        errors++;
        $display("[TB] FAIL signed_prod%0d: got %h expected %h", i, out_prod, ve[i]);
      end
      wait_sig("signed_idle", 1, 20);
      @(negedge Clk);
    end
  endtask

  task automatic test_done_hold();
    bit held = 1'b1;
    stub_hold = 3;
    out_ready = 1'b0;
    offer(4'd3, 4'd4, 1'b0);
    wait_sig("hold_done", 2, 20);
    for (int i = 0; i < 10 && mul_done === 1'b1; i++) begin
      if (busy !== 1'b1) held = 1'b0;
      @(negedge Clk);
    end
    checks++;
    if (!held || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_recover: busy got %b expected 1 until done drops", busy);
    end
    wait_sig("hold_idle", 1, 20);
    checks++;
    if ({out_valid, out_prod} !== {1'b1, 8'h0C}) begin
      errors++;
      $display("[TB] FAIL hold_prod: got %h expected 10c", {out_valid, out_prod});
    end
    out_ready = 1'b1;
    @(negedge Clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_single_push: out_valid got %b expected 0", out_valid);
    end
    stub_hold = 1;
  endtask

  task automatic test_timeout();
    int n = 0;
    bit stayed = 1'b1;
    out_ready = 1'b1;
    stub_hang = 1'b1;
    offer(4'd5, 4'd5, 1'b0);
    for (int i = 0; i < TIMEOUT + 10; i++) begin
      @(negedge Clk);
      n++;
      if (err === 1'b1) break;
    end
    checks++;
    if (n !== TIMEOUT + 1 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT + 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_no_push: out_valid got %b expected 0", out_valid);
    end
    stub_kick = 1'b1;
    wait_sig("timeout_idle", 1, 20);
    stub_kick = 1'b0;
    stub_hang = 1'b0;
    in_a = 4'd1; in_b = 4'd1; in_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || mul_idle !== 1'b1) stayed = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!stayed) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: in_ready got %b expected 0 (err %b)", in_ready, err);
    end
  endtask

  task automatic test_reset_in_wait();
    bit quiet = 1'b1;
    do_reset();
    out_ready = 1'b0;
    offer(4'd1, 4'd2, 1'b0);
    wait_sig("rst_idle", 1, 20);
    stub_latency = 10;
    offer(4'd3, 4'd3, 1'b0);
    repeat (2) @(negedge Clk);
    checks++;
    if ({busy, out_valid} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rst_pre: got %b expected 11", {busy, out_valid});
    end
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    checks++;
    if ({busy, out_valid, err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_wait: got %b expected 000", {busy, out_valid, err});
    end
    stray_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    stray_done = 1'b0;
    @(negedge Clk);
    if (out_valid !== 1'b0) quiet = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("[TB] FAIL rst_stray_done: out_valid got %b expected 0", out_valid);
    end
    stub_latency = 2;
    out_ready = 1'b1;
    offer(4'd2, 4'd2, 1'b0);
    wait_sig("rst_after_valid", 0, 20);
    checks++;
    if (out_prod !== 8'h04) begin
      errors++;
      $display("[TB] FAIL rst_after_op: got %h expected 04", out_prod);
    end
    wait_sig("rst_after_idle", 1, 20);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    @(negedge Clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_signed();
    test_done_hold();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
